// File: rtl/io_display_arb.sv
// rtl/io_display_arb.sv - round-robin write arbiter and register bank for the board HEX digits and LEDs
//
// Ports:
//   QClk, RstQnnnH     clock, asynchronous active-high reset
//   ReqValid/ReqAddr   per-requester write request and target (0 = HEX word, 1 = LED word)
//   ReqData            per-requester 24-bit data, slice r = [24r+23:24r]
//   ReqGrant, Busy     registered one-hot grant, high during the WRITE cycle
//   DispEn             0 blanks every digit and LED without touching the registers
//   HEX0..HEX5, LED    active-low segments (bit0 = a .. bit6 = g), active-high LEDs

module io_display_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic                  QClk,
    input  logic                  RstQnnnH,
    input  logic [NUM_REQ-1:0]    ReqValid,
    input  logic [NUM_REQ-1:0]    ReqAddr,
    input  logic [NUM_REQ*24-1:0] ReqData,
    output logic [NUM_REQ-1:0]    ReqGrant,
    output logic                  Busy,
    input  logic                  DispEn,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic [6:0]            HEX5,
    output logic [9:0]            LED
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_q;
    logic               lat_addr;
    logic [23:0]        lat_data;
    logic [23:0]        hex_reg;
    logic [9:0]         led_reg;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W:0]     scan;

    // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
    // One extra bit on scan keeps the sum from overflowing before the wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(NUM_REQ)) begin
                scan = scan - (PTR_W+1)'(NUM_REQ);
            end
            if (!win_found && ReqValid[scan]) begin
                win_found = 1'b1;
                win_idx   = scan[PTR_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state == WRITE);
    end

    // Grant, latched request and display registers. Addr/data are captured only
    // in the selecting IDLE cycle, so later requester changes cannot corrupt the write.
    always_ff @(posedge QClk or posedge RstQnnnH) begin
        if (RstQnnnH) begin
            ReqGrant <= '0;
            win_q    <= '0;
            lat_addr <= 1'b0;
            lat_data <= '0;
            hex_reg  <= '0;
            led_reg  <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        ReqGrant <= NUM_REQ'(1) << win_idx;
                        win_q    <= win_idx;
                        lat_addr <= ReqAddr[win_idx];
                        lat_data <= ReqData[24*win_idx +: 24];
                    end
                end
                WRITE: begin
                    ReqGrant <= '0;
                    if (lat_addr) begin
                        led_reg <= lat_data[9:0];
                    end else begin
                        hex_reg <= lat_data;
                    end
                    if (win_q == PTR_W'(NUM_REQ-1)) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= win_q + PTR_W'(1);
                    end
                end
                default: ReqGrant <= '0;
            endcase
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Blanking is purely combinational; registers keep updating while blanked.
    always_comb begin
        HEX0 = DispEn ? seg_decode(hex_reg[3:0])   : 7'h7F;
        HEX1 = DispEn ? seg_decode(hex_reg[7:4])   : 7'h7F;
        HEX2 = DispEn ? seg_decode(hex_reg[11:8])  : 7'h7F;
        HEX3 = DispEn ? seg_decode(hex_reg[15:12]) : 7'h7F;
        HEX4 = DispEn ? seg_decode(hex_reg[19:16]) : 7'h7F;
        HEX5 = DispEn ? seg_decode(hex_reg[23:20]) : 7'h7F;
        LED  = DispEn ? led_reg : 10'h000;
    end

endmodule

// File: tb/tb_io_display_arb.sv
// tb/tb_io_display_arb.sv - directed self-checking bench for io_display_arb

module tb_io_display_arb;

    localparam int NUM_REQ = 4;

    logic                  QClk = 1'b0;
    logic                  RstQnnnH;
    logic [NUM_REQ-1:0]    ReqValid;
    logic [NUM_REQ-1:0]    ReqAddr;
    logic [NUM_REQ*24-1:0] ReqData;
    logic [NUM_REQ-1:0]    ReqGrant;
    logic                  Busy;
    logic                  DispEn;
    logic [6:0]            HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]            LED;

    logic [6:0] hx [6];
    logic [6:0] exp_hx [6];

    int n_cmp = 0;
    int n_err = 0;

    io_display_arb #(.NUM_REQ(NUM_REQ)) dut (
        .QClk     (QClk),
        .RstQnnnH (RstQnnnH),
        .ReqValid (ReqValid),
        .ReqAddr  (ReqAddr),
        .ReqData  (ReqData),
        .ReqGrant (ReqGrant),
        .Busy     (Busy),
        .DispEn   (DispEn),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LED      (LED)
    );

    always #5 QClk = ~QClk;

    assign hx[0] = HEX0;
    assign hx[1] = HEX1;
    assign hx[2] = HEX2;
    assign hx[3] = HEX3;
    assign hx[4] = HEX4;
    assign hx[5] = HEX5;

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    task automatic post(input int r, input logic a, input logic [23:0] d);
        ReqAddr[r]        = a;
        ReqData[r*24 +: 24] = d;
        ReqValid[r]       = 1'b1;
    endtask

    task automatic test_reset();
        RstQnnnH = 1'b1;
        ReqValid = '0;
        ReqAddr  = '0;
        ReqData  = '0;
        DispEn   = 1'b1;
        tick();
        tick();
        RstQnnnH = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (hx[k] !== 7'h40) begin
                n_err++;
                $display("FAIL reset_hex%0d: got %h expected 40", k, hx[k]);
            end
        end
        n_cmp++;
        if (LED !== 10'h000) begin
            n_err++;
            $display("FAIL reset_led: got %h expected 000", LED);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++;
            if (ReqGrant !== 4'b0000 || Busy !== 1'b0) begin
                n_err++;
                $display("FAIL idle_cycle%0d: grant %b busy %b expected 0000 0", c, ReqGrant, Busy);
            end
        end
    endtask

    task automatic test_single_hex();
        post(2, 1'b0, 24'h89ABCD);
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b0100 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL hex_grant: grant %b busy %b expected 0100 1", ReqGrant, Busy);
        end
        ReqValid = '0;
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b0000 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL hex_grant_drop: grant %b busy %b expected 0000 0", ReqGrant, Busy);
        end
        exp_hx[0] = 7'h21; exp_hx[1] = 7'h46; exp_hx[2] = 7'h03;
        exp_hx[3] = 7'h08; exp_hx[4] = 7'h10; exp_hx[5] = 7'h00;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (hx[k] !== exp_hx[k]) begin
                n_err++;
                $display("FAIL hex_digit%0d: got %h expected %h", k, hx[k], exp_hx[k]);
            end
        end
    endtask

    task automatic test_led_write();
        post(1, 1'b1, 24'hFFF2AA);
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b0010) begin
            n_err++;
            $display("FAIL led_grant: got %b expected 0010", ReqGrant);
        end
        ReqValid = '0;
        tick();
        n_cmp++;
        if (LED !== 10'h2AA) begin
            n_err++;
            $display("FAIL led_value: got %h expected 2aa", LED);
        end
        n_cmp++;
        if (HEX0 !== 7'h21 || HEX5 !== 7'h00) begin
            n_err++;
            $display("FAIL led_hex_kept: HEX0 %h HEX5 %h expected 21 00", HEX0, HEX5);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        RstQnnnH = 1'b1;
        ReqAddr  = 4'b1010;
        ReqData[0*24 +: 24] = 24'h111111;
        ReqData[1*24 +: 24] = 24'h000155;
        ReqData[2*24 +: 24] = 24'hFEDCBA;
        ReqData[3*24 +: 24] = 24'h0003C3;
        ReqValid = 4'b1111;
        tick();
        RstQnnnH = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_g = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
            n_cmp++;
            if (ReqGrant !== exp_g || Busy !== (exp_g != 4'b0000)) begin
                n_err++;
                $display("FAIL rr_cycle%0d: grant %b busy %b expected %b %b", k, ReqGrant, Busy, exp_g, exp_g != 4'b0000);
            end
        end
        ReqValid = '0;
        n_cmp++;
        if (HEX0 !== 7'h08 || HEX5 !== 7'h0E) begin
            n_err++;
            $display("FAIL rr_hex_last: HEX0 %h HEX5 %h expected 08 0e", HEX0, HEX5);
        end
        n_cmp++;
        if (LED !== 10'h3C3) begin
            n_err++;
            $display("FAIL rr_led_last: got %h expected 3c3", LED);
        end
    endtask

    task automatic test_pointer_wrap();
        ReqValid = '0;
        tick();
        post(3, 1'b1, 24'h000005);
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b1000) begin
            n_err++;
            $display("FAIL wrap_first: got %b expected 1000", ReqGrant);
        end
        ReqValid = '0;
        tick();
        post(0, 1'b1, 24'h0000AA);
        post(3, 1'b1, 24'h000055);
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_req0: got %b expected 0001", ReqGrant);
        end
        ReqValid[0] = 1'b0;
        tick();
        n_cmp++;
        if (LED !== 10'h0AA) begin
            n_err++;
            $display("FAIL wrap_led0: got %h expected 0aa", LED);
        end
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b1000) begin
            n_err++;
            $display("FAIL wrap_req3: got %b expected 1000", ReqGrant);
        end
        ReqValid = '0;
        tick();
        n_cmp++;
        if (LED !== 10'h055) begin
            n_err++;
            $display("FAIL wrap_led3: got %h expected 055", LED);
        end
    endtask

    task automatic test_reset_mid_write_and_blank();
        tick();
        post(0, 1'b0, 24'h111111);
        tick();
        n_cmp++;
        if (ReqGrant !== 4'b0001 || Busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_grant: grant %b busy %b expected 0001 1", ReqGrant, Busy);
        end
        RstQnnnH = 1'b1;
        ReqValid = '0;
        #1;
        n_cmp++;
        if (ReqGrant !== 4'b0000 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async_drop: grant %b busy %b expected 0000 0", ReqGrant, Busy);
        end
        tick();
        RstQnnnH = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (hx[k] !== 7'h40) begin
                n_err++;
                $display("FAIL midrst_hex%0d: got %h expected 40", k, hx[k]);
            end
        end
        n_cmp++;
        if (LED !== 10'h000) begin
            n_err++;
            $display("FAIL midrst_led: got %h expected 000", LED);
        end
        DispEn = 1'b0;
        post(0, 1'b0, 24'h123456);
        ReqData[1*24 +: 24] = 24'h000000;
        tick();
        ReqValid = '0;
        tick();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (hx[k] !== 7'h7F) begin
                n_err++;
                $display("FAIL blank_hex%0d: got %h expected 7f", k, hx[k]);
            end
        end
        n_cmp++;
        if (LED !== 10'h000) begin
            n_err++;
            $display("FAIL blank_led: got %h expected 000", LED);
        end
        DispEn = 1'b1;
        #1;
        exp_hx[0] = 7'h02; exp_hx[1] = 7'h12; exp_hx[2] = 7'h19;
        exp_hx[3] = 7'h30; exp_hx[4] = 7'h24; exp_hx[5] = 7'h79;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (hx[k] !== exp_hx[k]) begin
                n_err++;
                $display("FAIL unblank_hex%0d: got %h expected %h", k, hx[k], exp_hx[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hex();
        test_led_write();
        test_round_robin();
        test_pointer_wrap();
        test_reset_mid_write_and_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
